// File: rtl/fifo_pkg.sv
// ============================================================================
// Package     : fifo_pkg
// Description : Shared asynchronous-FIFO constants and Gray/binary helpers.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  // Default geometry; DEPTH must equal 2**ADDR_WIDTH.
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 16;
  localparam int PTR_W      = ADDR_WIDTH + 1;
  localparam bit DEPTH_OK   = (DEPTH == (2 ** ADDR_WIDTH));

  // Widest pointer the helpers handle. Callers zero-extend and truncate, so
  // one pair of functions serves every pointer width.
  localparam int MAX_PTR_W = 32;
  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it; zero upper
  // bits from zero-extension leave the result unaffected.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wr_full_gen_if.sv
// ============================================================================
// Interface   : wr_full_gen_if
// Description : Pointer and status bundle between write controller, read
//               domain and the write-side full generator.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wr_full_gen_if #(
  parameter int PTR_W = 5
);
  logic [PTR_W-1:0] wr_ptr_ext;
  logic             wr_inc;
  logic [PTR_W-1:0] rd_ptr_gray;
  logic [PTR_W-1:0] wr_ptr_gray;
  logic             full;
  logic             almost_full;
  logic [PTR_W-1:0] wr_level;

  // Side that supplies pointers and consumes flags.
  modport master (
    output wr_ptr_ext, wr_inc, rd_ptr_gray,
    input  wr_ptr_gray, full, almost_full, wr_level
  );

  // The status generator itself.
  modport slave (
    input  wr_ptr_ext, wr_inc, rd_ptr_gray,
    output wr_ptr_gray, full, almost_full, wr_level
  );
endinterface

`default_nettype wire

// File: rtl/ptr_sync.sv
// ============================================================================
// Module      : ptr_sync
// Description : Multi-flop bus synchroniser for Gray-coded pointers. No logic
//               between stages; async active-low reset clears every stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift chain: stage 0 captures the asynchronous bus, later stages copy.
  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/wr_full_gen.sv
// ============================================================================
// Module      : wr_full_gen
// Description : Write-domain status generator for the asynchronous FIFO.
//               Exports the Gray write pointer, synchronises the read Gray
//               pointer and registers full, almost_full and fill level, all
//               evaluated against the next write pointer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wr_full_gen
  import fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = DEPTH - 2
) (
  input  wire logic      wr_clk,
  input  wire logic      rst_n,
  wr_full_gen_if.slave   bus
);

  localparam int            PW     = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  // Parameter legality, caught at elaboration.
  if (DEPTH != (2 ** ADDR_WIDTH)) begin : g_depth_chk
    $error("wr_full_gen: DEPTH must equal 2**ADDR_WIDTH");
  end
  if (ADDR_WIDTH < 2) begin : g_aw_chk
    $error("wr_full_gen: ADDR_WIDTH must be at least 2");
  end
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_sync_chk
    $error("wr_full_gen: SYNC_STAGES must be 2..4");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_af_chk
    $error("wr_full_gen: AF_THRESH must be 1..DEPTH");
  end

  logic [PW-1:0] rd_gray_s;
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] rd_gray_full;
  logic [PW-1:0] nxt_bin;
  logic [PW-1:0] nxt_gray;
  logic [PW-1:0] nxt_level;

  logic [PW-1:0] wr_ptr_gray_d, wr_ptr_gray_q;
  logic [PW-1:0] wr_level_d,    wr_level_q;
  logic          full_d,        full_q;
  logic          almost_full_d, almost_full_q;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk   (wr_clk),
    .rst_n (rst_n),
    .din   (bus.rd_ptr_gray),
    .dout  (rd_gray_s)
  );

  // Next pointer, its Gray form, and the level it implies against the
  // synchronised read pointer. Full is the Gray "top two bits inverted" match.
  always_comb begin
    nxt_bin       = bus.wr_ptr_ext + PW'(bus.wr_inc);
    nxt_gray      = PW'(bin2gray(ptr_max_t'(nxt_bin)));
    rd_bin_s      = PW'(gray2bin(ptr_max_t'(rd_gray_s)));
    nxt_level     = nxt_bin - rd_bin_s;
    rd_gray_full  = {~rd_gray_s[ADDR_WIDTH:ADDR_WIDTH-1], rd_gray_s[ADDR_WIDTH-2:0]};
    wr_ptr_gray_d = nxt_gray;
    wr_level_d    = nxt_level;
    full_d        = (nxt_gray == rd_gray_full);
    almost_full_d = (nxt_level >= AF_LVL);
  end

  // Export and flag registers; everything seen outside is a flop output.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_gray_q <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_gray_q <= wr_ptr_gray_d;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign bus.wr_ptr_gray = wr_ptr_gray_q;
  assign bus.wr_level    = wr_level_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;

`ifndef SYNTHESIS
  // A write presented while full is a write-controller protocol error.
  a_no_write_when_full : assert property (
    @(posedge wr_clk) disable iff (!rst_n) !(bus.wr_inc && full_q)
  ) else $error("wr_full_gen: wr_inc asserted while full");
`endif

endmodule

`default_nettype wire

// File: tb/tb_wr_full_gen.sv
// ============================================================================
// Module      : tb_wr_full_gen
// Description : Self-checking bench for wr_full_gen with a scoreboard of
//               expected post-edge outputs and a read-pointer delay model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wr_full_gen;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int S     = 2;
  localparam int AF    = DEPTH - 2;

  typedef struct packed {
    logic [4:0] gray;
    logic [4:0] level;
    logic       full;
    logic       af;
  } exp_t;

  logic wr_clk = 1'b0;
  logic rst_n  = 1'b0;

  wr_full_gen_if #(.PTR_W(AW + 1)) bus ();

  wr_full_gen #(
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (S),
    .AF_THRESH   (AF)
  ) dut (
    .wr_clk (wr_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t       sb[$];
  logic [4:0] hist[$];
  logic [4:0] wp;
  logic [4:0] rp;
  logic       last_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_clear();
    sb.delete();
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back(5'd0);
    wp        = '0;
    rp        = '0;
    last_full = 1'b0;
  endtask

  // One write-clock cycle: drive, predict, clock, compare.
  task automatic step(input logic inc, input int rd_adv);
    exp_t       e;
    logic [4:0] nxt;
    logic [4:0] used;
    @(negedge wr_clk);
    rp              = rp + 5'(rd_adv);
    bus.wr_inc      = inc;
    bus.wr_ptr_ext  = wp;
    bus.rd_ptr_gray = to_gray(rp);
    used    = hist[0];
    nxt     = wp + 5'(inc);
    e.gray  = to_gray(nxt);
    e.level = nxt - used;
    e.full  = (e.level == 5'(DEPTH));
    e.af    = (e.level >= 5'(AF));
    sb.push_back(e);
    @(posedge wr_clk);
    #1;
    void'(hist.pop_front());
    hist.push_back(rp);
    wp = nxt;
    e  = sb.pop_front();
    chk("gray",  32'(bus.wr_ptr_gray), 32'(e.gray));
    chk("level", 32'(bus.wr_level),    32'(e.level));
    chk("full",  32'(bus.full),        32'(e.full));
    chk("af",    32'(bus.almost_full), 32'(e.af));
    last_full = e.full;
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    bus.wr_inc = 1'b0;
    bus.wr_ptr_ext = '0;
    bus.rd_ptr_gray = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge wr_clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    int cnt;
    int adv;
    logic [4:0] avail;
    logic [4:0] tru;
    bus.wr_inc = 1'b0;
    bus.wr_ptr_ext = '0;
    bus.rd_ptr_gray = '0;
    model_clear();
    do_reset();

    // Reset mid-traffic: outputs clear asynchronously and stay clear.
    for (int i = 0; i < 5; i++) step(1'b1, (i > 1) ? 1 : 0);
    @(negedge wr_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gray",  32'(bus.wr_ptr_gray), 32'd0);
    chk("rst_level", 32'(bus.wr_level),    32'd0);
    chk("rst_full",  32'(bus.full),        32'd0);
    chk("rst_af",    32'(bus.almost_full), 32'd0);
    bus.wr_inc = 1'b0;
    bus.wr_ptr_ext = '0;
    bus.rd_ptr_gray = '0;
    repeat (3) @(negedge wr_clk);
    chk("rst_hold_lvl", 32'(bus.wr_level), 32'd0);
    rst_n = 1'b1;
    model_clear();
    step(1'b0, 0);

    // Fill with the read pointer parked at zero.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 0);
      chk("fill_lvl",  32'(bus.wr_level),    32'(i));
      chk("fill_af",   32'(bus.almost_full), 32'(i >= 14));
      chk("fill_full", 32'(bus.full),        32'(i == DEPTH));
    end
    chk("fill_gray", 32'(bus.wr_ptr_gray), 32'(5'b11000));

    // Drain visibility: one read, count edges until full drops.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i == 0) ? 1 : 0);
      cnt++;
      if (!bus.full) break;
    end
    chk("drain_lat",  32'(cnt),             32'(S + 1));
    chk("drain_lvl",  32'(bus.wr_level),    32'd15);
    chk("drain_af",   32'(bus.almost_full), 32'd1);

    // Write coinciding with a synchronised read at level 15.
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 0);
    step(1'b0, 1);
    for (int i = 0; i < S - 1; i++) step(1'b0, 0);
    step(1'b1, 0);
    chk("same_lvl",  32'(bus.wr_level), 32'd15);
    chk("same_full", 32'(bus.full),     32'd0);

    // Pointer wrap with a small, steady level.
    do_reset();
    wp = 5'd28;
    rp = 5'd25;
    for (int i = 0; i < S + 1; i++) step(1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      avail = wp - rp;
      step(1'b1, (avail >= 5'd4) ? 1 : 0);
      chk("wrap_nofull", 32'(bus.full), 32'd0);
    end

    // Randomised read-rate profiles against the scoreboard.
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 3400; i++) begin
        avail = wp - rp;
        case (ph)
          0:       adv = ($urandom_range(0, 2) == 0) ? 1 : 0;
          1:       adv = int'($urandom_range(0, 3));
          default: adv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : 1;
        endcase
        if (adv > int'(avail)) adv = int'(avail);
        step(!last_full && ($urandom_range(0, 3) != 0), adv);
        tru = wp - rp;
        chk("lvl_ge_true", 32'(bus.wr_level >= tru), 32'd1);
        chk("lvl_le_depth", 32'(bus.wr_level <= 5'(DEPTH)), 32'd1);
        chk("not_optimistic", 32'((tru == 5'(DEPTH)) ? bus.full : 1'b1), 32'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute run bound.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
